dm_wbuf: RTL and testbench
==========================

# dm_wbuf

Word-granular store buffer between the pipelined CPU's memory stage and the data memory `dm`. Stores from the CPU are accepted into a small FIFO and retired to `dm` in cycles where the memory port is free, so the CPU does not wait on a slow or busy memory. Loads read `dm` directly and are forwarded from pending buffered stores so the CPU always sees program-order data. The block sits in `pipecomp` in place of the direct CPU-to-`dm` wiring.

## Interface
- `DEPTH`, 4: number of buffer entries; power of two, 2..16.
- `AW`, 7: dm word-address width; CPU byte address bits `[AW+1:2]` are used.
- `DW`, 32: data width.

- `clk`  in  1  CPU clock, rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `cpu_we`  in  1  store request (MemWrite) from memory stage.
- `cpu_re`  in  1  load request from memory stage; never high together with `cpu_we`.
- `cpu_fence`  in  1  drain request; hold CPU until buffer empty.
- `cpu_addr`  in  32  byte address (aluout).
- `cpu_wdata`  in  DW  store data.
- `cpu_rdata`  out  DW  load data, combinational.
- `cpu_stall`  out  1  freeze memory stage and earlier this cycle.
- `dm_we`  out  1  dm write strobe (DMWr).
- `dm_addr`  out  AW  dm word address.
- `dm_din`  out  DW  dm write data.
- `dm_dout`  in  DW  dm asynchronous read data.
- `dm_ready`  in  1  dm can accept/serve an access this cycle; tie 1 for zero-wait dm.
- `wb_empty`  out  1  no pending entries.

## Operation
- FIFO of `{addr[AW-1:0], data[DW-1:0]}`, head/tail pointers `log2(DEPTH)` bits with wrap, `count` 0..DEPTH.
- Drain: when `count>0 && dm_ready && !cpu_re`, head entry drives `dm_addr/dm_din`, `dm_we=1`, head advances at edge. Otherwise `dm_we=0`, `dm_addr` = load address, `dm_din` = 0.
- Store accept: `cpu_we && (count<DEPTH || drain)` → write tail, tail advances. Full with no drain → `cpu_stall=1`, store not taken, retried next cycle.
- Store and drain in same cycle: both happen, `count` unchanged.
- Load: word address compared against all valid entries; youngest match (nearest tail) supplies `cpu_rdata` (forward). No match: `cpu_rdata=dm_dout`; if `dm_ready=0`, `cpu_stall=1`. A forwarded load never stalls.
- Load blocks drain for its cycle; loads always win the port.
- Fence: `cpu_stall=1` while `cpu_fence && count>0`; drain continues; released the cycle `count==0`.
- Same-address stores queue independently; retirement in FIFO order gives last-writer-wins.

## Timing
- Reset (rstn low at edge): head=tail=count=0, entries invalid. While `rstn=0`: `dm_we=0`, `cpu_stall=0`, `wb_empty=1`, `dm_din=0`, `cpu_rdata=dm_dout`.
- Reset mid-drain: pending entries are discarded, not written.
- Store at edge N → earliest dm write in cycle N+1 (one-cycle latency when idle).
- `cpu_stall`, `cpu_rdata`, `dm_*` are combinational from state and inputs; `wb_empty` is `count==0`.
- Minimum retirement: one entry per cycle.

## Configuration
- `DM_WBUF_FWD_EN` defined: store-to-load forwarding as above.
- Undefined: no comparators; a load whose word address matches any valid entry asserts `cpu_stall` until that address has drained, with drain allowed to proceed despite `cpu_re`. Non-matching loads behave identically.

## Structure
- Package `dm_wbuf_pkg`: entry struct type, pointer width function `clog2`, default DEPTH/AW/DW constants.
- Sub-module `wbuf_fifo`: storage, pointers, count, full/empty, and per-entry valid vector for the match logic. Match/priority/stall logic stays in `dm_wbuf`.

## Test plan
- Idle store: `cpu_we`, addr 0x10, data 0xDEADBEEF, `dm_ready=1` → next cycle `dm_we=1`, `dm_addr=4`, `dm_din=0xDEADBEEF`, then `wb_empty=1`.
- Fill: `dm_ready=0`, stores to 0x0,0x4,0x8,0xC accepted, fifth store → `cpu_stall=1`; raise `dm_ready` → fifth accepted same cycle 0x0 drains, retirement order 0,1,2,3,4.
- Forward: store 0x20←0x11, then 0x20←0x22 pending, load 0x20 → `cpu_rdata=0x22`, no stall; without `DM_WBUF_FWD_EN` → stall until both drained, then `dm_dout` returns 0x22.
- Load priority: 2 pending, `cpu_re` every cycle for 3 cycles → `dm_we=0` those cycles, drain resumes after.
- Fence: 3 pending, `cpu_fence=1` → `cpu_stall=1` exactly 3 cycles with `dm_ready=1`.
- Reset mid-drain: 3 pending, `rstn=0` one edge → `wb_empty=1`, no further `dm_we`.

Source files
------------

// File: rtl/dm_wbuf_pkg.sv
// dm_wbuf shared types and defaults.
// Optional feature macro: DM_WBUF_FWD_EN (store-to-load forwarding).
package dm_wbuf_pkg;

    localparam int WB_DEPTH = 4;
    localparam int WB_AW    = 7;
    localparam int WB_DW    = 32;

    typedef struct packed {
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/dm_wbuf_if.sv
// CPU memory-stage and dm port bundle for the store buffer.
// The buffer sits on the slave side; the master is the CPU/dm pair.
interface dm_wbuf_if #(
    parameter int AW = 7,
    parameter int DW = 32
);
    logic          cpu_we;
    logic          cpu_re;
    logic          cpu_fence;
    logic [31:0]   cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_din;
    logic [DW-1:0] dm_dout;
    logic          dm_ready;
    logic          wb_empty;

    modport master (
        output cpu_we, cpu_re, cpu_fence, cpu_addr, cpu_wdata,
        output dm_dout, dm_ready,
        input  cpu_rdata, cpu_stall, dm_we, dm_addr, dm_din, wb_empty
    );

    modport slave (
        input  cpu_we, cpu_re, cpu_fence, cpu_addr, cpu_wdata,
        input  dm_dout, dm_ready,
        output cpu_rdata, cpu_stall, dm_we, dm_addr, dm_din, wb_empty
    );

endinterface

// File: rtl/dm_wbuf_fifo.sv
// wbuf_fifo: store-buffer storage, head/tail pointers, count and
// per-entry valid bits exposed for the address match logic.
module wbuf_fifo
    import dm_wbuf_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW,
    parameter int PW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    output logic [AW-1:0] o_addr [DEPTH],
    output logic [DW-1:0] o_data [DEPTH],
    output logic [DEPTH-1:0] o_vld,
    output logic [PW-1:0] o_head,
    output logic          o_full,
    output logic          o_empty
);
    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW:0]      r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr[r_tail] <= i_waddr;
            r_data[r_tail] <= i_wdata;
        end
    end

    // pop before push: on a full-and-draining cycle head == tail
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            if (i_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + 1'b1;
            end
            if (i_push) begin
                r_vld[r_tail] <= 1'b1;
                r_tail        <= r_tail + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_addr  = r_addr;
    assign o_data  = r_data;
    assign o_vld   = r_vld;
    assign o_head  = r_head;
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/dm_wbuf.sv
// dm_wbuf: word store buffer between CPU memory stage and dm.
// Define DM_WBUF_FWD_EN for store-to-load forwarding; else matching loads stall.
module dm_wbuf
    import dm_wbuf_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic     clk,
    input  logic     rstn,
    dm_wbuf_if.slave bus
);
    localparam int PW = clog2(DEPTH);

    logic [AW-1:0]    w_addr [DEPTH];
    logic [DW-1:0]    w_data [DEPTH];
    logic [DEPTH-1:0] w_vld;
    logic [PW-1:0]    w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_drain;
    logic             w_hit;
    logic             w_ldstall;
    logic [AW-1:0]    w_laddr;
    logic             w_unused;

    assign w_laddr  = bus.cpu_addr[AW+1:2];
    assign w_unused = ^{bus.cpu_addr[31:AW+2], bus.cpu_addr[1:0]};

    wbuf_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PW(PW)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_pop   (w_drain),
        .i_waddr (w_laddr),
        .i_wdata (bus.cpu_wdata),
        .o_addr  (w_addr),
        .o_data  (w_data),
        .o_vld   (w_vld),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef DM_WBUF_FWD_EN
    logic [DW-1:0] w_fdata;

    // walk oldest to youngest so the last match left standing is youngest
    always_comb begin
        w_hit   = 1'b0;
        w_fdata = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_vld[w_head + PW'(k)] &&
                w_addr[w_head + PW'(k)] == w_laddr) begin
                w_hit   = 1'b1;
                w_fdata = w_data[w_head + PW'(k)];
            end
        end
    end

    assign w_drain = rstn && !w_empty && bus.dm_ready && !bus.cpu_re;
    assign w_ldstall = bus.cpu_re && !w_hit && !bus.dm_ready;
    assign bus.cpu_rdata = (rstn && w_hit) ? w_fdata : bus.dm_dout;
`else
    always_comb begin
        w_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++)
            if (w_vld[k] && w_addr[k] == w_laddr) w_hit = 1'b1;
    end

    // a matching load gives up the port so its address can drain
    assign w_drain = rstn && !w_empty && bus.dm_ready &&
                     (!bus.cpu_re || w_hit);
    assign w_ldstall = bus.cpu_re && (w_hit || !bus.dm_ready);
    assign bus.cpu_rdata = bus.dm_dout;
`endif

    assign w_push = rstn && bus.cpu_we && (!w_full || w_drain);

    assign bus.cpu_stall = rstn &&
        ((bus.cpu_we && w_full && !w_drain) || w_ldstall ||
         (bus.cpu_fence && !w_empty));

    assign bus.dm_we    = w_drain;
    assign bus.dm_addr  = w_drain ? w_addr[w_head] : w_laddr;
    assign bus.dm_din   = w_drain ? w_data[w_head] : '0;
    assign bus.wb_empty = w_empty || !rstn;

endmodule

// File: tb/tb_dm_wbuf.sv
// Directed bench for dm_wbuf with a behavioural zero-wait dm model.
// Expectations follow DM_WBUF_FWD_EN when it is defined for the build.
module tb_dm_wbuf;

    logic clk;
    logic rstn;
    int   n_vec;
    int   n_bad;
    int   start;
    int   stalls;

    logic [31:0] mem [128] = '{3: 32'hCAFE0003, default: 32'h0};
    logic [38:0] wlog [$];

    dm_wbuf_if #(.AW(7), .DW(32)) bus ();

    dm_wbuf #(.DEPTH(4), .AW(7), .DW(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.dm_dout = mem[bus.dm_addr];

    always @(posedge clk) begin
        if (bus.dm_we) begin
            mem[bus.dm_addr] <= bus.dm_din;
            wlog.push_back({bus.dm_addr, bus.dm_din});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [38:0] obs,
                       input logic [38:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic re, input logic fn,
                         input logic [31:0] a, input logic [31:0] d);
        bus.cpu_we    = we;
        bus.cpu_re    = re;
        bus.cpu_fence = fn;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        #1;
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 20 && !bus.wb_empty; i++) tick();
        chk(tag, 39'(bus.wb_empty), 39'd1);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rstn  = 1'b0;
        bus.dm_ready = 1'b1;
        drive(0, 1, 0, 32'hC, 0);

        // reset behaviour
        chk("rst_empty0", 39'(bus.wb_empty), 39'd1);
        tick();
        tick();
        chk("rst_empty", 39'(bus.wb_empty), 39'd1);
        chk("rst_we", 39'(bus.dm_we), 39'd0);
        chk("rst_stall", 39'(bus.cpu_stall), 39'd0);
        chk("rst_din", 39'(bus.dm_din), 39'd0);
        chk("rst_rdata", 39'(bus.cpu_rdata), 39'h0CAFE0003);
        rstn = 1'b1;
        drive(0, 0, 0, 0, 0);

        // idle store
        drive(1, 0, 0, 32'h10, 32'hDEADBEEF);
        chk("st_stall", 39'(bus.cpu_stall), 39'd0);
        chk("st_we0", 39'(bus.dm_we), 39'd0);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("st_we1", 39'(bus.dm_we), 39'd1);
        chk("st_addr", 39'(bus.dm_addr), 39'd4);
        chk("st_din", 39'(bus.dm_din), 39'hDEADBEEF);
        chk("st_pend", 39'(bus.wb_empty), 39'd0);
        tick();
        chk("st_done", 39'(bus.wb_empty), 39'd1);
        chk("st_mem", 39'(mem[4]), 39'hDEADBEEF);

        // fill, stall on fifth, accept while draining
        bus.dm_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 32'(4 * i), 32'h100 + 32'(i));
            chk("fill_stall", 39'(bus.cpu_stall), 39'd0);
            tick();
        end
        drive(1, 0, 0, 32'h10, 32'h104);
        chk("full_stall1", 39'(bus.cpu_stall), 39'd1);
        tick();
        chk("full_stall2", 39'(bus.cpu_stall), 39'd1);
        chk("full_nowe", 39'(bus.dm_we), 39'd0);
        bus.dm_ready = 1'b1;
        #1;
        start = wlog.size();
        chk("full_go", 39'(bus.cpu_stall), 39'd0);
        chk("full_head", {bus.dm_addr, bus.dm_din}, {7'd0, 32'h100});
        tick();
        drive(0, 0, 0, 0, 0);
        wait_empty("fill_drain");
        chk("fill_cnt", 39'(wlog.size() - start), 39'd5);
        for (int i = 0; i < 5; i++)
            if (start + i < wlog.size())
                chk("fill_order", wlog[start + i],
                    {7'(i), 32'h100 + 32'(i)});

        // same-address stores then a load of that word
        bus.dm_ready = 1'b0;
        drive(1, 0, 0, 32'h20, 32'h11);
        tick();
        drive(1, 0, 0, 32'h20, 32'h22);
        tick();
        drive(0, 1, 0, 32'h20, 0);
`ifdef DM_WBUF_FWD_EN
        chk("fwd_data", 39'(bus.cpu_rdata), 39'h22);
        chk("fwd_stall", 39'(bus.cpu_stall), 39'd0);
        bus.dm_ready = 1'b1;
        #1;
        chk("fwd_nowe", 39'(bus.dm_we), 39'd0);
        chk("fwd_data2", 39'(bus.cpu_rdata), 39'h22);
        tick();
        drive(0, 0, 0, 0, 0);
        wait_empty("fwd_drain");
        drive(0, 1, 0, 32'h20, 0);
`else
        chk("nf_stall0", 39'(bus.cpu_stall), 39'd1);
        bus.dm_ready = 1'b1;
        #1;
        chk("nf_stall1", 39'(bus.cpu_stall), 39'd1);
        chk("nf_dr1", {bus.dm_addr, bus.dm_din}, {7'd8, 32'h11});
        tick();
        chk("nf_stall2", 39'(bus.cpu_stall), 39'd1);
        chk("nf_dr2", {bus.dm_addr, bus.dm_din}, {7'd8, 32'h22});
        tick();
`endif
        chk("ld_stall", 39'(bus.cpu_stall), 39'd0);
        chk("ld_data", 39'(bus.cpu_rdata), 39'h22);
        chk("ld_empty", 39'(bus.wb_empty), 39'd1);

        // loads win the port
        drive(0, 0, 0, 0, 0);
        bus.dm_ready = 1'b0;
        drive(1, 0, 0, 32'h40, 32'hA1);
        tick();
        drive(1, 0, 0, 32'h44, 32'hA2);
        tick();
        bus.dm_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 32'h80, 0);
            chk("lp_nowe", 39'(bus.dm_we), 39'd0);
            chk("lp_addr", 39'(bus.dm_addr), 39'h20);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        chk("lp_dr1", {bus.dm_we, bus.dm_addr, bus.dm_din},
            39'({1'b1, 7'h10, 32'hA1}));
        tick();
        chk("lp_dr2", {bus.dm_we, bus.dm_addr, bus.dm_din},
            39'({1'b1, 7'h11, 32'hA2}));
        tick();
        chk("lp_empty", 39'(bus.wb_empty), 39'd1);

        // fence holds the CPU until drained
        bus.dm_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 32'h50 + 32'(4 * i), 32'hB0 + 32'(i));
            tick();
        end
        bus.dm_ready = 1'b1;
        drive(0, 0, 1, 0, 0);
        stalls = 0;
        for (int i = 0; i < 10 && bus.cpu_stall; i++) begin
            stalls++;
            tick();
        end
        chk("fence_cycles", 39'(stalls), 39'd3);
        chk("fence_empty", 39'(bus.wb_empty), 39'd1);
        drive(0, 0, 0, 0, 0);

        // reset mid-drain discards pending stores
        bus.dm_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 32'h60 + 32'(4 * i), 32'hC0 + 32'(i));
            tick();
        end
        drive(0, 0, 0, 0, 0);
        bus.dm_ready = 1'b1;
        #1;
        start = wlog.size();
        chk("rd_we", 39'(bus.dm_we), 39'd1);
        tick();
        rstn = 1'b0;
        #1;
        chk("rd_rst_we", 39'(bus.dm_we), 39'd0);
        chk("rd_rst_empty", 39'(bus.wb_empty), 39'd1);
        tick();
        rstn = 1'b1;
        #1;
        chk("rd_empty", 39'(bus.wb_empty), 39'd1);
        chk("rd_nowe", 39'(bus.dm_we), 39'd0);
        tick();
        tick();
        chk("rd_writes", 39'(wlog.size() - start), 39'd1);
        chk("rd_mem0", 39'(mem[7'h18]), 39'hC0);
        chk("rd_mem1", 39'(mem[7'h19]), 39'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
